// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - multi-channel key debouncer with press, release and long-press pulses
module key_debounce_multi #(
  parameter int   N_KEYS      = 4,
  parameter int   SAMPLE_TIME = 500000,
  parameter int   LONG_TIME   = 100000000,
  parameter int   CNT_W       = 27,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_out,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMING,
    ST_HELD,
    ST_LONG,
    ST_DISARMING
  } state_t;

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] LONG_SAT    = CNT_W'(LONG_TIME);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic             s1_q;
    logic             s2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] hold_d;
    state_t           state_q;
    state_t           state_d;
    logic             out_q;
    logic             press_q;
    logic             release_q;
    logic             long_q;
    logic             flip;
    logic             pressed;

    // Two-flop synchroniser for the raw asynchronous key level
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q <= IDLE_LEVEL;
        s2_q <= IDLE_LEVEL;
      end else begin
        s1_q <= key_in[g];
        s2_q <= s1_q;
      end
    end

    // Debounced level is pressed in HELD, LONG and while counting toward release
    assign pressed = (state_q == ST_HELD) || (state_q == ST_LONG) ||
                     (state_q == ST_DISARMING);

    // Next-state: stable-time filter, hold counter and channel state
    always_comb begin
      flip   = 1'b0;
      db_d   = db_q;
      cnt_d  = '0;
      hold_d = hold_q;
      if (s2_q != db_q) begin
        if (cnt_q == SAMPLE_LAST) begin
          flip = 1'b1;
          db_d = s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      if (flip) begin
        hold_d = '0;
      end else if (pressed && (hold_q < LONG_SAT)) begin
        hold_d = hold_q + 1'b1;
      end
      if (db_d == IDLE_LEVEL) begin
        state_d = (cnt_d != '0) ? ST_ARMING : ST_IDLE;
      end else if (cnt_d != '0) begin
        state_d = ST_DISARMING;
      end else begin
        state_d = (hold_d == LONG_SAT) ? ST_LONG : ST_HELD;
      end
    end

    // Channel FSM with registered level and event pulses
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_q      <= IDLE_LEVEL;
        cnt_q     <= '0;
        hold_q    <= '0;
        state_q   <= ST_IDLE;
        out_q     <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        db_q      <= db_d;
        cnt_q     <= cnt_d;
        hold_q    <= hold_d;
        state_q   <= state_d;
        out_q     <= (db_d != IDLE_LEVEL);
        press_q   <= flip && (s2_q != IDLE_LEVEL);
        release_q <= flip && (s2_q == IDLE_LEVEL);
        long_q    <= !flip && pressed && (hold_q == LONG_LAST);
      end
    end

    assign key_out[g]     = out_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_long[g]    = long_q;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - randomized bench for key_debounce_multi against a window-based model
module tb_key_debounce_multi;

  localparam int S = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] kin0, kin1;
  logic [1:0] o0, p0, r0, l0;
  logic [1:0] o1, p1, r1, l1;

  always #5 clk = ~clk;

  key_debounce_multi #(
    .N_KEYS(2), .SAMPLE_TIME(S), .LONG_TIME(L), .CNT_W(8), .IDLE_LEVEL(1'b0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .key_in(kin0),
    .key_out(o0), .key_press(p0), .key_release(r0), .key_long(l0)
  );

  key_debounce_multi #(
    .N_KEYS(2), .SAMPLE_TIME(S), .LONG_TIME(L), .CNT_W(8), .IDLE_LEVEL(1'b1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .key_in(kin1),
    .key_out(o1), .key_press(p1), .key_release(r1), .key_long(l1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per channel, the raw samples taken at each edge; the
  // debounced level changes at an edge when the S most recent samples visible
  // behind the two-flop synchroniser all differ from it.
  logic idle_l [2];
  logic hist   [2][2][8];
  logic db_m   [2][2];
  int   last_flip [2][2];
  int   edge_n;
  logic e_out [2][2];
  logic e_prs [2][2];
  logic e_rel [2][2];
  logic e_lng [2][2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 8; i++) hist[d][c][i] = idle_l[d];
        db_m[d][c]      = idle_l[d];
        last_flip[d][c] = -1000;
        e_out[d][c] = 1'b0;
        e_prs[d][c] = 1'b0;
        e_rel[d][c] = 1'b0;
        e_lng[d][c] = 1'b0;
      end
  endtask

  task automatic model_edge(input logic [1:0] k0, input logic [1:0] k1);
    logic flip;
    edge_n++;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        for (int i = 7; i > 0; i--) hist[d][c][i] = hist[d][c][i-1];
        hist[d][c][0] = (d == 0) ? k0[c] : k1[c];
        flip = 1'b1;
        for (int i = 2; i <= S + 1; i++)
          if (hist[d][c][i] == db_m[d][c]) flip = 1'b0;
        e_prs[d][c] = 1'b0;
        e_rel[d][c] = 1'b0;
        e_lng[d][c] = 1'b0;
        if (flip) begin
          db_m[d][c]      = ~db_m[d][c];
          last_flip[d][c] = edge_n;
          if (db_m[d][c] != idle_l[d]) e_prs[d][c] = 1'b1;
          else                         e_rel[d][c] = 1'b1;
        end else if (db_m[d][c] != idle_l[d] && edge_n - last_flip[d][c] == L) begin
          e_lng[d][c] = 1'b1;
        end
        e_out[d][c] = (db_m[d][c] != idle_l[d]);
      end
  endtask

  task automatic step(input logic [1:0] k0, input logic [1:0] k1);
    kin0 = k0;
    kin1 = k1;
    @(posedge clk);
    model_edge(k0, k1);
    #1;
    chk("dut0", {o0, p0, r0, l0},
        {e_out[0][1], e_out[0][0], e_prs[0][1], e_prs[0][0],
         e_rel[0][1], e_rel[0][0], e_lng[0][1], e_lng[0][0]});
    chk("dut1", {o1, p1, r1, l1},
        {e_out[1][1], e_out[1][0], e_prs[1][1], e_prs[1][0],
         e_rel[1][1], e_rel[1][0], e_lng[1][1], e_lng[1][0]});
  endtask

  // Asynchronous reset pulse between edges; outputs must drop before any edge
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_dut0", {o0, p0, r0, l0}, 8'h00);
    chk("rst_dut1", {o1, p1, r1, l1}, 8'h00);
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  // Apply inputs at edge k (j=0) and find the first later edge with a press on dut/ch
  task automatic lat_run(input int dut, input int ch, input logic [1:0] k0,
                         input logic [1:0] k1, output int lat, output logic [1:0] pv);
    lat = -1;
    pv  = 2'b00;
    step(k0, k1);
    for (int j = 1; j <= 10; j++) begin
      step(k0, k1);
      if (lat < 0 && ((dut == 0) ? p0[ch] : p1[ch])) begin
        lat = j;
        pv  = (dut == 0) ? p0 : p1;
      end
    end
  endtask

  int         lat;
  logic [1:0] pv;
  int         rem [2][2];
  logic       lvl [2][2];

  initial begin
    idle_l[0] = 1'b0;
    idle_l[1] = 1'b1;
    edge_n = 0;
    model_reset();
    kin0 = 2'b00;
    kin1 = 2'b11;
    rst  = 1'b1;
    #1;
    chk("init_dut0", {o0, p0, r0, l0}, 8'h00);
    chk("init_dut1", {o1, p1, r1, l1}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) step(2'b00, 2'b11);

    // Clean press on channel 0
    lat_run(0, 0, 2'b01, 2'b11, lat, pv);
    chk("press_lat", 8'(lat), 8'd5);
    chk("press_ch1_quiet", {6'd0, pv}, 8'h01);
    for (int i = 0; i < 12; i++) step(2'b00, 2'b11);

    // Bounce rejection, then a settled press
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++) step(2'b01, 2'b11);
      step(2'b00, 2'b11);
    end
    lat_run(0, 0, 2'b01, 2'b11, lat, pv);
    chk("bounce_press_lat", 8'(lat), 8'd5);
    for (int i = 0; i < 12; i++) step(2'b00, 2'b11);

    // Long press on channel 1 then release
    for (int i = 0; i < 40; i++) step(2'b10, 2'b11);
    for (int i = 0; i < 12; i++) step(2'b00, 2'b11);

    // Short press on channel 0
    for (int i = 0; i < 12; i++) step(2'b01, 2'b11);
    for (int i = 0; i < 12; i++) step(2'b00, 2'b11);

    // Active-low keys, both channels together
    lat_run(1, 0, 2'b00, 2'b00, lat, pv);
    chk("conc_press_lat", 8'(lat), 8'd5);
    chk("conc_press_both", {6'd0, pv}, 8'h03);
    for (int i = 0; i < 12; i++) step(2'b00, 2'b11);

    // Mid-operation reset while channel 0 is held
    for (int i = 0; i < 10; i++) step(2'b01, 2'b11);
    do_reset();
    lat_run(0, 0, 2'b01, 2'b11, lat, pv);
    chk("rst_press_lat", 8'(lat), 8'd5);
    for (int i = 0; i < 12; i++) step(2'b00, 2'b11);

    // Randomized bouncy and held levels on all channels of both instances
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) begin
        rem[d][c] = 0;
        lvl[d][c] = idle_l[d];
      end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < 2; c++) begin
          if (rem[d][c] == 0) begin
            lvl[d][c] = 1'($urandom_range(0, 1));
            rem[d][c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40))
                                                    : int'($urandom_range(1, 5));
          end
          rem[d][c]--;
        end
      step({lvl[0][1], lvl[0][0]}, {lvl[1][1], lvl[1][0]});
      if ($urandom_range(0, 399) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
